bc_timing_control: RTL
======================

Name: bc_timing_control

Overview:
- Control unit of the basic 16-bit computer.
- Reads the current T-state from the 4-bit sequence counter and the instruction register, and drives the counter's inc/clr inputs.
- Emits every register-transfer strobe for fetch, decode, indirect, execute and interrupt cycles.
- Holds the control flip-flops I, D, R, IEN and S (run). All datapath registers sample the strobes at posedge clk.

Parameters:
- T_MAX, 6: highest legal T-state. A seq value above T_MAX is illegal.
- START_RUNNING, 1: reset value of S.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low, sampled at posedge clk.
- seq  in  4  current T-state from the sequence counter.
- ir  in  16  instruction register: bit 15 = I, bits 14:12 = opcode, bits 11:0 = address or micro-op bits.
- ac_zero, ac_sign, dr_zero, e_flag  in  1  datapath status.
- fgi, fgo  in  1  input/output device flags.
- start  in  1  pulse; sets S.
- sc_inc, sc_clr  out  1  sequence counter controls; never both 1.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- ld_ar, inc_ar, clr_ar, ld_pc, inc_pc, clr_pc, ld_dr, inc_dr, ld_ir, ld_tr, ld_ac  out  1  register strobes.
- alu_op  out  4  AC/E operation: 0 none, 1 AND, 2 ADD, 3 LOAD(DR), 4 CLA, 5 CLE, 6 CMA, 7 CME, 8 CIR, 9 CIL, 10 INC, 11 INP.
- mem_rd, mem_wr, ld_outr, clr_fgi, clr_fgo  out  1  memory and I/O strobes.
- running, int_cycle, illegal  out  1  status (S, R, and illegal-state flag).

Behaviour:
- Outputs are combinational from seq, the latched D/I, R, S, ir and the status inputs. State flip-flops update at posedge clk.
- rst_n=0: S=START_RUNNING, R=0, IEN=0, I=0, D=0, illegal=0. All strobes and alu_op are 0, bus_sel=0, sc_clr=1, sc_inc=0.
- S=0 (halted): all strobes 0, sc_clr=1. On start=1: S<=1, and fetch begins at T0 on the next cycle.
- Default while running: sc_inc=1, sc_clr=0, except on any terminating cycle listed below, where sc_clr=1 and sc_inc=0.
- Fetch (R=0):
  - T0: bus_sel=PC, ld_ar.
  - T1: mem_rd, bus_sel=MEM, ld_ir, inc_pc.
  - T2: bus_sel=IR, ld_ar; at posedge, D<=ir[14:12] and I<=ir[15].
- T3, D!=7, I=1: mem_rd, bus_sel=MEM, ld_ar (indirect). T3, D!=7, I=0: no-op.
- Memory-reference execute, terminating as noted:
  - D0/D1/D2: T4 mem_rd, bus_sel=MEM, ld_dr. T5 ld_ac with alu_op AND/ADD/LOAD; terminate.
  - D3 (STA): T4 bus_sel=AC, mem_wr; terminate.
  - D4 (BUN): T4 bus_sel=AR, ld_pc; terminate.
  - D5 (BSA): T4 bus_sel=PC, mem_wr, inc_ar. T5 bus_sel=AR, ld_pc; terminate.
  - D6 (ISZ): T4 read into DR. T5 inc_dr. T6 bus_sel=DR, mem_wr, inc_pc if dr_zero; terminate.
- D=7, I=0, T3 (register reference): decode the single set bit of ir[11:0].
  - Bits 11..5 = CLA, CLE, CMA, CME, CIR, CIL, INC → alu_op with ld_ac.
  - Bit 4 SPA: inc_pc if !ac_sign. Bit 3 SNA: inc_pc if ac_sign. Bit 2 SZA: inc_pc if ac_zero. Bit 1 SZE: inc_pc if !e_flag.
  - Bit 0 HLT: S<=0.
  - Terminate.
- D=7, I=1, T3 (I/O): decode ir[11:6].
  - INP: alu_op=INP, clr_fgi.
  - OUT: ld_outr, bus_sel=AC, clr_fgo.
  - SKI: inc_pc if fgi. SKO: inc_pc if fgo.
  - ION: IEN<=1. IOF: IEN<=0.
  - Terminate.
- Zero or more than one bit set in ir for a register-reference or I/O instruction: execute nothing, pulse illegal, terminate.
- Interrupt entry: at posedge, R<=1 when S=1, R=0, seq is not 0, 1 or 2, IEN=1 and (fgi|fgo).
- Interrupt cycle (R=1), takes precedence over fetch:
  - T0: clr_ar, bus_sel=PC, ld_tr.
  - T1: bus_sel=TR, mem_wr, clr_pc.
  - T2: inc_pc; IEN<=0 and R<=0 at posedge; terminate.
- seq > T_MAX, or seq reaching a T-state with no defined action: illegal=1 for that cycle, sc_clr=1, no strobes.
- rst_n=0 mid-instruction aborts the instruction immediately. No strobe is asserted in the reset cycle.

Optional Feature:
- BASCOMP_INTERRUPT_EN defined: R/IEN logic and the interrupt cycle are present as specified.
- Undefined: R and IEN are removed; int_cycle is tied to 0; ION/IOF are legal no-ops that terminate; fetch is never pre-empted.

Test Plan:
- Reset, then ir=0x2005 (LDA 005): T0..T5 strobe sequence as specified; sc_clr at T5; ld_ac with alu_op=3 at T5.
- ir=0xC010 (BUN indirect): mem_rd plus ld_ar at T3; bus_sel=AR, ld_pc at T4; sc_clr at T4.
- ir=0x6020 (ISZ) with dr_zero=1 at T6: mem_wr and inc_pc both at T6. Repeat with dr_zero=0: no inc_pc.
- ir=0x7001 (HLT): S clears; running=0; sc_clr held at 1 for 10 cycles. Pulse start: T0 fetch resumes the next cycle.
- BASCOMP_INTERRUPT_EN defined: ION, then fgi=1 during a T3 → int_cycle=1 at the next T0; clr_ar+ld_tr at T0, mem_wr+clr_pc at T1, inc_pc at T2; IEN=0 afterwards.
- ir=0x7003 (two register-reference bits set), and a separately forced seq=9: illegal=1 and sc_clr=1 in both cases; no other strobes.

Source files
------------

// File: rtl/bc_timing_control.sv
// Control unit for the basic 16-bit computer: decodes T-state, IR and flags into register-transfer strobes.
// Optional interrupt support (R, IEN, interrupt cycle) is built when BASCOMP_INTERRUPT_EN is defined.
module bc_timing_control #(
  parameter int   T_MAX         = 6,
  parameter logic START_RUNNING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  seq,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_sign,
  input  logic        dr_zero,
  input  logic        e_flag,
  input  logic        fgi,
  input  logic        fgo,
  input  logic        start,
  output logic        sc_inc,
  output logic        sc_clr,
  output logic [2:0]  bus_sel,
  output logic        ld_ar,
  output logic        inc_ar,
  output logic        clr_ar,
  output logic        ld_pc,
  output logic        inc_pc,
  output logic        clr_pc,
  output logic        ld_dr,
  output logic        inc_dr,
  output logic        ld_ir,
  output logic        ld_tr,
  output logic        ld_ac,
  output logic [3:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ld_outr,
  output logic        clr_fgi,
  output logic        clr_fgo,
  output logic        running,
  output logic        int_cycle,
  output logic        illegal
);

  localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3;
  localparam logic [3:0] T4 = 4'd4, T5 = 4'd5, T6 = 4'd6;
  localparam logic [3:0] SEQ_MAX = 4'(T_MAX);

  localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3;
  localparam logic [2:0] BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7;

  localparam logic [3:0] ALU_NONE = 4'd0, ALU_AND = 4'd1, ALU_ADD = 4'd2, ALU_LOAD = 4'd3;
  localparam logic [3:0] ALU_CLA = 4'd4, ALU_CLE = 4'd5, ALU_CMA = 4'd6, ALU_CME = 4'd7;
  localparam logic [3:0] ALU_CIR = 4'd8, ALU_CIL = 4'd9, ALU_INC = 4'd10, ALU_INP = 4'd11;

  logic       s, i, r;
  logic [2:0] d;
  logic       dload, hlt, ien_set, ien_clr, r_clr, term, bad;

  always_comb begin
    sc_inc  = 1'b0;  sc_clr  = 1'b0;  bus_sel = BUS_NONE; alu_op = ALU_NONE;
    ld_ar   = 1'b0;  inc_ar  = 1'b0;  clr_ar  = 1'b0;
    ld_pc   = 1'b0;  inc_pc  = 1'b0;  clr_pc  = 1'b0;
    ld_dr   = 1'b0;  inc_dr  = 1'b0;  ld_ir   = 1'b0;  ld_tr = 1'b0;  ld_ac = 1'b0;
    mem_rd  = 1'b0;  mem_wr  = 1'b0;  ld_outr = 1'b0;  clr_fgi = 1'b0;  clr_fgo = 1'b0;
    illegal = 1'b0;  dload   = 1'b0;  hlt     = 1'b0;
    ien_set = 1'b0;  ien_clr = 1'b0;  r_clr   = 1'b0;  term = 1'b0;  bad = 1'b0;
    if (rst_n && s) begin
      if (seq > SEQ_MAX) begin
        bad = 1'b1;
      end else if (r && seq <= T2) begin
        // Interrupt cycle: save PC at address 0, then continue from address 1
        case (seq)
          T0:      begin clr_ar = 1'b1; bus_sel = BUS_PC; ld_tr = 1'b1; end
          T1:      begin bus_sel = BUS_TR; mem_wr = 1'b1; clr_pc = 1'b1; end
          default: begin inc_pc = 1'b1; r_clr = 1'b1; term = 1'b1; end
        endcase
      end else begin
        case (seq)
          T0: begin bus_sel = BUS_PC; ld_ar = 1'b1; end
          T1: begin mem_rd = 1'b1; bus_sel = BUS_MEM; ld_ir = 1'b1; inc_pc = 1'b1; end
          T2: begin bus_sel = BUS_IR; ld_ar = 1'b1; dload = 1'b1; end
          T3: begin
            if (d == 3'd7) begin
              // Register-reference and I/O words must carry exactly one micro-op bit
              if (!$onehot(ir[11:0]) || (i && ir[5:0] != 6'd0)) begin
                bad = 1'b1;
              end else if (!i) begin
                term = 1'b1;
                if      (ir[11]) begin alu_op = ALU_CLA; ld_ac = 1'b1; end
                else if (ir[10]) begin alu_op = ALU_CLE; ld_ac = 1'b1; end
                else if (ir[9])  begin alu_op = ALU_CMA; ld_ac = 1'b1; end
                else if (ir[8])  begin alu_op = ALU_CME; ld_ac = 1'b1; end
                else if (ir[7])  begin alu_op = ALU_CIR; ld_ac = 1'b1; end
                else if (ir[6])  begin alu_op = ALU_CIL; ld_ac = 1'b1; end
                else if (ir[5])  begin alu_op = ALU_INC; ld_ac = 1'b1; end
                else if (ir[4])  inc_pc = !ac_sign;
                else if (ir[3])  inc_pc = ac_sign;
                else if (ir[2])  inc_pc = ac_zero;
                else if (ir[1])  inc_pc = !e_flag;
                else             hlt = 1'b1;
              end else begin
                term = 1'b1;
                if      (ir[11]) begin alu_op = ALU_INP; clr_fgi = 1'b1; end
                else if (ir[10]) begin ld_outr = 1'b1; bus_sel = BUS_AC; clr_fgo = 1'b1; end
                else if (ir[9])  inc_pc = fgi;
                else if (ir[8])  inc_pc = fgo;
                else if (ir[7])  ien_set = 1'b1;
                else             ien_clr = 1'b1;
              end
            end else if (i) begin
              mem_rd = 1'b1; bus_sel = BUS_MEM; ld_ar = 1'b1;
            end
          end
          T4: begin
            case (d)
              3'd0, 3'd1, 3'd2, 3'd6: begin mem_rd = 1'b1; bus_sel = BUS_MEM; ld_dr = 1'b1; end
              3'd3:    begin bus_sel = BUS_AC; mem_wr = 1'b1; term = 1'b1; end
              3'd4:    begin bus_sel = BUS_AR; ld_pc = 1'b1; term = 1'b1; end
              3'd5:    begin bus_sel = BUS_PC; mem_wr = 1'b1; inc_ar = 1'b1; end
              default: bad = 1'b1;
            endcase
          end
          T5: begin
            case (d)
              3'd0:    begin ld_ac = 1'b1; alu_op = ALU_AND;  term = 1'b1; end
              3'd1:    begin ld_ac = 1'b1; alu_op = ALU_ADD;  term = 1'b1; end
              3'd2:    begin ld_ac = 1'b1; alu_op = ALU_LOAD; term = 1'b1; end
              3'd5:    begin bus_sel = BUS_AR; ld_pc = 1'b1; term = 1'b1; end
              3'd6:    inc_dr = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          T6: begin
            if (d == 3'd6) begin
              bus_sel = BUS_DR; mem_wr = 1'b1; inc_pc = dr_zero; term = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      if (bad) begin
        illegal = 1'b1;
        sc_clr  = 1'b1;
      end else if (term) begin
        sc_clr = 1'b1;
      end else begin
        sc_inc = 1'b1;
      end
    end else begin
      sc_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= START_RUNNING;
      i <= 1'b0;
      d <= 3'd0;
    end else begin
      if (start)    s <= 1'b1;
      else if (hlt) s <= 1'b0;
      if (dload) begin
        d <= ir[14:12];
        i <= ir[15];
      end
    end
  end

`ifdef BASCOMP_INTERRUPT_EN
  logic ien;

  // R is raised only once the fetch phase is over so the current instruction completes first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r   <= 1'b0;
      ien <= 1'b0;
    end else if (r_clr) begin
      r   <= 1'b0;
      ien <= 1'b0;
    end else begin
      if (s && !r && seq >= T3 && ien && (fgi || fgo)) r <= 1'b1;
      if (ien_set)      ien <= 1'b1;
      else if (ien_clr) ien <= 1'b0;
    end
  end
`else
  logic unused_int;
  assign r          = 1'b0;
  assign unused_int = ^{ien_set, ien_clr, r_clr};
`endif

  assign running   = s;
  assign int_cycle = r;

endmodule
